button_conditioner: RTL and testbench



---
 rtl/button_conditioner_if.sv | 10 +
 rtl/button_conditioner.sv | 78 +++++++
 tb/tb_button_conditioner.sv | 119 +++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button pin in, debounced level and event strobes out
interface button_conditioner_if;
    logic btn_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    modport master(output btn_n, input pressed, press_pulse, release_pulse, long_pulse);
    modport slave(input btn_n, output pressed, press_pulse, release_pulse, long_pulse);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces an active-low button into a level plus press/release/long strobes
module button_conditioner #(
    parameter int COUNT_WIDTH    = 32,
    parameter int DEBOUNCE_COUNT = 240000 - 1,
    parameter int HOLD_COUNT     = 12000000 - 1
) (
    input logic clk,
    input logic rst,
    button_conditioner_if.slave b
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;
    localparam logic [COUNT_WIDTH-1:0] DC  = COUNT_WIDTH'(DEBOUNCE_COUNT);
    localparam logic [COUNT_WIDTH-1:0] HC  = COUNT_WIDTH'(HOLD_COUNT);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    logic [1:0] state;
    logic sync1, btn_s, long_done, rel_acc, holding;
    logic [COUNT_WIDTH-1:0] cnt, hold;

    // a release accepted this edge wins over a long strobe due on the same edge
    assign rel_acc = state == RELEASE_WAIT && !btn_s && cnt == DC;
    assign holding = (state == PRESSED || state == RELEASE_WAIT) && !rel_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1           <= 1'b0;
            btn_s           <= 1'b0;
            state           <= IDLE;
            cnt             <= '0;
            hold            <= '0;
            long_done       <= 1'b0;
            b.pressed       <= 1'b0;
            b.press_pulse   <= 1'b0;
            b.release_pulse <= 1'b0;
            b.long_pulse    <= 1'b0;
        end else begin
            sync1           <= ~b.btn_n;
            btn_s           <= sync1;
            b.press_pulse   <= 1'b0;
            b.release_pulse <= 1'b0;
            b.long_pulse    <= 1'b0;
            case (state)
                IDLE: if (btn_s) begin
                    state <= PRESS_WAIT;
                    cnt   <= '0;
                end
                PRESS_WAIT: if (!btn_s) state <= IDLE;
                else if (cnt == DC) begin
                    state         <= PRESSED;
                    b.pressed     <= 1'b1;
                    b.press_pulse <= 1'b1;
                    hold          <= '0;
                    long_done     <= 1'b0;
                end else cnt <= cnt + ONE;
                PRESSED: if (!btn_s) begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                end
                RELEASE_WAIT: if (btn_s) state <= PRESSED;
                else if (cnt == DC) begin
                    state           <= IDLE;
                    b.pressed       <= 1'b0;
                    b.release_pulse <= 1'b1;
                end else cnt <= cnt + ONE;
                default: state <= IDLE;
            endcase
            if (holding) begin
                if (hold == HC && !long_done) begin
                    b.long_pulse <= 1'b1;
                    long_done    <= 1'b1;
                end else if (hold != HC) hold <= hold + ONE;
            end
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed button traffic against a run-length debounce model
module tb_button_conditioner;
    localparam int D = 3;
    localparam int H = 10;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int run = 0;
    int press_at = -1000;
    logic [1:0] pipe = 2'b00;
    logic acc = 1'b0;
    logic was, seen;
    logic e_pr = 1'b0, e_pp = 1'b0, e_rp = 1'b0, e_lp = 1'b0;

    button_conditioner_if bif();
    button_conditioner #(.COUNT_WIDTH(W), .DEBOUNCE_COUNT(D), .HOLD_COUNT(H)) dut (
        .clk(clk),
        .rst(rst),
        .b(bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            bif.btn_n = v;
            @(negedge clk);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // a level is accepted once D+2 consecutive synchronized samples disagree with it
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            pipe = 2'b00;
            acc = 1'b0;
            run = 0;
            press_at = -1000;
            {e_pr, e_pp, e_rp, e_lp} = 4'b0;
        end else begin
            seen = pipe[1];
            pipe = {pipe[0], ~bif.btn_n};
            was = acc;
            {e_pp, e_rp} = 2'b0;
            run = (seen != acc) ? run + 1 : 0;
            if (run == D + 2) begin
                acc = seen;
                run = 0;
                e_pp = acc;
                e_rp = !acc;
                if (acc) press_at = cyc;
            end
            e_lp = was && acc && (cyc - press_at == H + 1);
            e_pr = acc;
        end
    end

    initial forever begin
        @(negedge clk);
        check("pressed", bif.pressed, e_pr);
        check("press_pulse", bif.press_pulse, e_pp);
        check("release_pulse", bif.release_pulse, e_rp);
        check("long_pulse", bif.long_pulse, e_lp);
        check("one_hot", $countones({bif.press_pulse, bif.release_pulse, bif.long_pulse}) <= 1, 1'b1);
    end

    initial begin
        bif.btn_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1, 10);
        drive(0, 40);
        drive(1, 12);
        repeat (4) begin
            drive(0, 3);
            drive(1, 3);
        end
        drive(0, 10);
        drive(1, 2);
        drive(0, 10);
        drive(1, 12);
        drive(0, 8);
        drive(1, 12);
        drive(0, 11);
        drive(1, 12);
        drive(0, 12);
        drive(1, 12);
        drive(0, 10);
        pulse_rst();
        drive(0, 12);
        drive(1, 12);
        repeat (300) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 16));
            if ($urandom_range(0, 40) == 0) pulse_rst();
        end
        drive(1, 15);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
